// File: rtl/bsg_decode_mask_tracker.sv
// bsg_decode_mask_tracker
//
// Keeps a registered occupancy mask of width_p slots. Binary slot addresses
// arrive on a set port (with ready) and a clear port (always accepted). Each
// address is decoded to a one-hot bit, and the mask updates as
// (mask & ~clr) | set, so a clear applies before a set. The block also keeps
// a running population count, full/empty flags, and one-cycle protocol-error
// pulses for the owning allocator.
//
// Ports:
//   clk_i             clock, rising edge
//   reset_n_i         synchronous active-low reset
//   set_v_i           set request valid
//   set_addr_i        slot to set
//   set_ready_o       registered; a set is accepted when set_v_i & set_ready_o
//   clr_v_i           clear request valid, always accepted
//   clr_addr_i        slot to clear
//   mask_o            registered occupancy mask
//   count_o           registered popcount of mask_o
//   empty_o           registered, count_o == 0
//   full_o            registered, count_o == width_p
//   err_double_set_o  pulse: set of a slot that is still occupied
//   err_clr_unset_o   pulse: clear of a slot that is not occupied
//   err_range_o       pulse: set or clear address >= width_p
module bsg_decode_mask_tracker #(
  parameter int width_p    = 32,
  parameter int lg_width_p = $clog2(width_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  set_v_i,
  input  logic [lg_width_p-1:0] set_addr_i,
  output logic                  set_ready_o,
  input  logic                  clr_v_i,
  input  logic [lg_width_p-1:0] clr_addr_i,
  output logic [width_p-1:0]    mask_o,
  output logic [lg_width_p:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  err_double_set_o,
  output logic                  err_clr_unset_o,
  output logic                  err_range_o
);

  localparam int                  cnt_w    = lg_width_p + 1;
  localparam logic [cnt_w-1:0]    full_cnt = cnt_w'(width_p);
  localparam logic [width_p-1:0]  one_lsb  = width_p'(1);

  // An address at or beyond width_p shifts the single bit out of the vector,
  // so the decode is all zeros exactly when the address is out of range.
  function automatic logic [width_p-1:0] decode(input logic [lg_width_p-1:0] a);
    return one_lsb << a;
  endfunction

  function automatic logic in_range(input logic [lg_width_p-1:0] a);
    return |decode(a);
  endfunction

  logic                 set_acc;
  logic [width_p-1:0]   set_dec;
  logic [width_p-1:0]   clr_dec;
  logic [width_p-1:0]   mask_cleared;
  logic [width_p-1:0]   mask_next;
  logic                 eff_set;
  logic                 eff_clr;
  logic                 dbl_set;
  logic                 clr_unset;
  logic                 range_err;
  logic [cnt_w-1:0]     count_next;

  logic [width_p-1:0]   mask_p1;
  logic [cnt_w-1:0]     count_p1;
  logic                 empty_p1;
  logic                 full_p1;
  logic                 ready_p1;
  logic                 dbl_set_p1;
  logic                 clr_unset_p1;
  logic                 range_err_p1;

  assign set_acc      = set_v_i & ready_p1;
  assign set_dec      = set_acc ? decode(set_addr_i) : '0;
  assign clr_dec      = clr_v_i ? decode(clr_addr_i) : '0;
  assign mask_cleared = mask_p1 & ~clr_dec;
  assign mask_next    = mask_cleared | set_dec;

  // A same-slot set+clear of an occupied bit counts as one clear and one
  // set, which cancels in the count and raises no error.
  assign eff_clr   = |(clr_dec & mask_p1);
  assign eff_set   = |(set_dec & ~mask_cleared);
  assign dbl_set   = |(set_dec & mask_cleared);
  assign clr_unset = (|clr_dec) & ~eff_clr;
  assign range_err = (set_acc & ~in_range(set_addr_i))
                   | (clr_v_i & ~in_range(clr_addr_i));

  always_comb begin
    count_next = count_p1;
    case ({eff_set, eff_clr})
      2'b10:   count_next = count_p1 + cnt_w'(1);
      2'b01:   count_next = count_p1 - cnt_w'(1);
      default: count_next = count_p1;
    endcase
  end

  // p1: registered state and error pulses
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      mask_p1      <= '0;
      count_p1     <= '0;
      empty_p1     <= 1'b1;
      full_p1      <= 1'b0;
      ready_p1     <= 1'b0;
      dbl_set_p1   <= 1'b0;
      clr_unset_p1 <= 1'b0;
      range_err_p1 <= 1'b0;
    end else begin
      mask_p1      <= mask_next;
      count_p1     <= count_next;
      empty_p1     <= (count_next == '0);
      full_p1      <= (count_next == full_cnt);
      ready_p1     <= (count_next != full_cnt);
      dbl_set_p1   <= dbl_set;
      clr_unset_p1 <= clr_unset;
      range_err_p1 <= range_err;
    end
  end

  assign mask_o           = mask_p1;
  assign count_o          = count_p1;
  assign empty_o          = empty_p1;
  assign full_o           = full_p1;
  assign set_ready_o      = ready_p1;
  assign err_double_set_o = dbl_set_p1;
  assign err_clr_unset_o  = clr_unset_p1;
  assign err_range_o      = range_err_p1;

endmodule

// File: tb/tb_bsg_decode_mask_tracker.sv
module tb_bsg_decode_mask_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] mask;
    logic [5:0]  count;
    logic        empty;
    logic        full;
    logic        ready;
    logic        eds;
    logic        ecu;
    logic        erng;
  } obs_t;

  typedef struct {
    string nm;
    bit    d20;
    obs_t  e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // 32-slot instance
  logic        sv32 = 1'b0, cv32 = 1'b0;
  logic [4:0]  sa32 = '0, ca32 = '0;
  logic        rdy32, e32, f32, eds32, ecu32, erng32;
  logic [31:0] m32;
  logic [5:0]  c32;

  bsg_decode_mask_tracker #(.width_p(32)) dut32 (
    .clk_i(clk), .reset_n_i(rst_n),
    .set_v_i(sv32), .set_addr_i(sa32), .set_ready_o(rdy32),
    .clr_v_i(cv32), .clr_addr_i(ca32),
    .mask_o(m32), .count_o(c32), .empty_o(e32), .full_o(f32),
    .err_double_set_o(eds32), .err_clr_unset_o(ecu32), .err_range_o(erng32)
  );

  // 20-slot instance, for out-of-range addresses
  logic        sv20 = 1'b0, cv20 = 1'b0;
  logic [4:0]  sa20 = '0, ca20 = '0;
  logic        rdy20, e20, f20, eds20, ecu20, erng20;
  logic [19:0] m20;
  logic [5:0]  c20;

  bsg_decode_mask_tracker #(.width_p(20)) dut20 (
    .clk_i(clk), .reset_n_i(rst_n),
    .set_v_i(sv20), .set_addr_i(sa20), .set_ready_o(rdy20),
    .clr_v_i(cv20), .clr_addr_i(ca20),
    .mask_o(m20), .count_o(c20), .empty_o(e20), .full_o(f20),
    .err_double_set_o(eds20), .err_clr_unset_o(ecu20), .err_range_o(erng20)
  );

  obs_t obs32, obs20;
  assign obs32 = '{mask: m32, count: c32, empty: e32, full: f32, ready: rdy32,
                   eds: eds32, ecu: ecu32, erng: erng32};
  assign obs20 = '{mask: {12'b0, m20}, count: c20, empty: e20, full: f20, ready: rdy20,
                   eds: eds20, ecu: ecu20, erng: erng20};

  // Drive one cycle of inputs on the falling edge and queue the outputs
  // expected just after the following rising edge.
  task automatic step(input string nm, input bit d20, input bit rn,
                      input bit sv, input logic [4:0] sa,
                      input bit cv, input logic [4:0] ca,
                      input logic [31:0] m, input int c, input bit rdy,
                      input bit eds, input bit ecu, input bit erng);
    exp_t x;
    @(negedge clk);
    rst_n = rn;
    sv32 = d20 ? 1'b0 : sv;  sa32 = sa;  cv32 = d20 ? 1'b0 : cv;  ca32 = ca;
    sv20 = d20 ? sv : 1'b0;  sa20 = sa;  cv20 = d20 ? cv : 1'b0;  ca20 = ca;
    x.nm  = nm;
    x.d20 = d20;
    x.e   = '{mask: m, count: 6'(c), empty: (c == 0),
              full: (c == (d20 ? 20 : 32)), ready: rdy,
              eds: eds, ecu: ecu, erng: erng};
    q.push_back(x);
  endtask

  // Monitor: compares the selected instance against the queued expectation
  initial begin
    exp_t x;
    obs_t act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x   = q.pop_front();
        act = x.d20 ? obs20 : obs32;
        checks++;
        if (act !== x.e) begin
          errors++;
          $display("FAIL %s: got mask=%h cnt=%0d e/f/rdy=%b%b%b err(ds,cu,rg)=%b%b%b want mask=%h cnt=%0d e/f/rdy=%b%b%b err=%b%b%b",
                   x.nm, act.mask, act.count, act.empty, act.full, act.ready,
                   act.eds, act.ecu, act.erng, x.e.mask, x.e.count, x.e.empty,
                   x.e.full, x.e.ready, x.e.eds, x.e.ecu, x.e.erng);
        end
      end
    end
  end

  initial begin
    logic [31:0] fm;

    // Reset, then release: ready rises one edge after release
    step("rst0",    0, 0, 0, 0,  0, 0,  32'h0, 0, 0, 0, 0, 0);
    step("rst1",    0, 0, 1, 3,  1, 4,  32'h0, 0, 0, 0, 0, 0);
    step("release", 0, 1, 0, 0,  0, 0,  32'h0, 0, 1, 0, 0, 0);

    // 20-slot instance: range errors and one pulse for both ports
    step("w20_set25",    1, 1, 1, 25, 0, 0,  32'h0, 0, 1, 0, 0, 1);
    step("w20_idle",     1, 1, 0, 0,  0, 0,  32'h0, 0, 1, 0, 0, 0);
    step("w20_set2",     1, 1, 1, 2,  0, 0,  32'h4, 1, 1, 0, 0, 0);
    step("w20_bothrng",  1, 1, 1, 25, 1, 30, 32'h4, 1, 1, 0, 0, 1);
    step("w20_clr19",    1, 1, 0, 0,  1, 19, 32'h4, 1, 1, 0, 1, 0);
    step("w20_clr2",     1, 1, 0, 0,  1, 2,  32'h0, 0, 1, 0, 0, 0);

    // Sets of 0, 5, 31 on consecutive cycles
    step("set0",  0, 1, 1, 0,  0, 0, 32'h0000_0001, 1, 1, 0, 0, 0);
    step("set5",  0, 1, 1, 5,  0, 0, 32'h0000_0021, 2, 1, 0, 0, 0);
    step("set31", 0, 1, 1, 31, 0, 0, 32'h8000_0021, 3, 1, 0, 0, 0);
    step("clr0",  0, 1, 0, 0,  1, 0,  32'h8000_0020, 2, 1, 0, 0, 0);
    step("clr5",  0, 1, 0, 0,  1, 5,  32'h8000_0000, 1, 1, 0, 0, 0);
    step("clr31", 0, 1, 0, 0,  1, 31, 32'h0000_0000, 0, 1, 0, 0, 0);

    // Double set and clear-of-unset
    step("set3",     0, 1, 1, 3, 0, 0, 32'h8, 1, 1, 0, 0, 0);
    step("set3_dbl", 0, 1, 1, 3, 0, 0, 32'h8, 1, 1, 1, 0, 0);
    step("clr9_uns", 0, 1, 0, 0, 1, 9, 32'h8, 1, 1, 0, 1, 0);
    step("idle_a",   0, 1, 0, 0, 0, 0, 32'h8, 1, 1, 0, 0, 0);

    // Same-slot set and clear of 12
    step("set12",        0, 1, 1, 12, 0, 0,  32'h1008, 2, 1, 0, 0, 0);
    step("sc12_occ",     0, 1, 1, 12, 1, 12, 32'h1008, 2, 1, 0, 0, 0);
    step("clr12",        0, 1, 0, 0,  1, 12, 32'h0008, 1, 1, 0, 0, 0);
    step("sc12_unset",   0, 1, 1, 12, 1, 12, 32'h1008, 2, 1, 0, 1, 0);
    step("idle_b",       0, 1, 0, 0,  0, 0,  32'h1008, 2, 1, 0, 0, 0);
    step("clr3",         0, 1, 0, 0,  1, 3,  32'h1000, 1, 1, 0, 0, 0);
    step("clr12b",       0, 1, 0, 0,  1, 12, 32'h0000, 0, 1, 0, 0, 0);

    // Fill all 32 slots
    for (int i = 0; i < 32; i++) begin
      fm = (i == 31) ? 32'hFFFF_FFFF : ((32'h1 << (i + 1)) - 32'h1);
      step($sformatf("fill%0d", i), 0, 1, 1, 5'(i), 0, 0, fm, i + 1, (i != 31), 0, 0, 0);
    end
    // Set while full is not accepted, so no double-set pulse
    step("full_set",  0, 1, 1, 7, 0, 0, 32'hFFFF_FFFF, 32, 0, 0, 0, 0);
    // Clear while full: the set offered in the same cycle still stalls
    step("full_clr7", 0, 1, 1, 7, 1, 7, 32'hFFFF_FF7F, 31, 1, 0, 0, 0);
    step("idle_c",    0, 1, 0, 0, 0, 0, 32'hFFFF_FF7F, 31, 1, 0, 0, 0);

    // Reset mid-stream with requests pending
    step("mid_rst",   0, 0, 1, 7, 1, 0, 32'h0, 0, 0, 0, 0, 0);
    step("mid_rel",   0, 1, 1, 4, 0, 0, 32'h0, 0, 1, 0, 0, 0);
    step("post_set4", 0, 1, 1, 4, 0, 0, 32'h10, 1, 1, 0, 0, 0);
    step("idle_d",    0, 1, 0, 0, 0, 0, 32'h10, 1, 1, 0, 0, 0);

    // Let the monitor drain, bounded
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_decode_mask_tracker.md
# bsg_decode_mask_tracker

Inverse companion to the priority encoder. It accepts binary slot addresses on a set port and a clear port, decodes each one to a one-hot bit, and keeps a registered occupancy mask of `width_p` bits. The mask feeds downstream priority encoders and arbiters. The block also keeps a running population count and full/empty flags, and flags protocol errors (double-set, clear-of-unset, out-of-range address) so the owning allocator can be checked in simulation and in silicon.

## Interface
Parameters:
- `width_p`, default 32: number of tracked slots (mask width); any value ≥ 2.
- `lg_width_p`, default `$clog2(width_p)`: address width; derived, never overridden.

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `reset_n_i`  in  1  reset; synchronous, active-low.
- `set_v_i`  in  1  set request valid.
- `set_addr_i`  in  `lg_width_p`  slot to set.
- `set_ready_o`  out  1  set port ready; registered. A set is accepted when `set_v_i & set_ready_o`.
- `clr_v_i`  in  1  clear request; always accepted, no ready.
- `clr_addr_i`  in  `lg_width_p`  slot to clear.
- `mask_o`  out  `width_p`  registered occupancy mask; bit k set means slot k is occupied.
- `count_o`  out  `lg_width_p+1`  registered popcount of `mask_o`.
- `empty_o`  out  1  registered; equals (`count_o == 0`).
- `full_o`  out  1  registered; equals (`count_o == width_p`).
- `err_double_set_o`  out  1  one-cycle pulse.
- `err_clr_unset_o`  out  1  one-cycle pulse.
- `err_range_o`  out  1  one-cycle pulse.

## Operation
- Decode: address a maps to the one-hot vector with bit a set. When a ≥ `width_p`, the decode is all zeros and the range error fires.
- Per cycle, form `set_dec` from an accepted set and `clr_dec` from a valid clear. Either one is zero when its request is absent.
- Next mask is `(mask & ~clr_dec) | set_dec`. The clear applies first, then the set.
- Double-set: an accepted, in-range set whose bit is already 1 in `(mask & ~clr_dec)`. The mask is unchanged and `err_double_set_o` pulses.
- Clear-of-unset: a valid, in-range clear whose bit is 0 in `mask`. The mask is unchanged for that bit and `err_clr_unset_o` pulses.
- Range error: an accepted set or a valid clear with address ≥ `width_p`. The request is ignored and `err_range_o` pulses. One pulse covers both ports.
- Same address on both ports in one cycle:
  - Bit currently 1: the bit stays 1, no error, count unchanged.
  - Bit currently 0: `err_clr_unset_o` pulses and the bit becomes 1.
- Count update is incremental: +1 for an effective set (bit 0 to 1), −1 for an effective clear (bit 1 to 0), both or neither gives no change. Width is `lg_width_p+1`; it never wraps, since the mask bounds it to 0..`width_p`.
- `full_o` and `empty_o` are derived from the next count and registered.
- `set_ready_o` is registered and equals the next value of `~full_o`. While full, sets stall even if a clear is in flight that cycle; ready reasserts the cycle after the clear lands.

## Timing
- Reset (`reset_n_i` low at a rising edge):
  - `mask_o`=0, `count_o`=0, `empty_o`=1, `full_o`=0.
  - All error outputs 0, `set_ready_o`=0.
  - Inputs are ignored during reset.
- First edge after reset releases: `set_ready_o` goes to 1.
- Reset mid-operation: pending requests in that cycle are dropped; the state returns to the reset values above.
- Latency: a request accepted at edge N appears on `mask_o`, `count_o`, `full_o`, `empty_o` and `set_ready_o` in the cycle after edge N. Error pulses appear in the same cycle and last exactly one cycle.
- No combinational paths from inputs to any output.

## Test plan
- Reset, then set addresses 0, 5, 31 on consecutive cycles. Required: `mask_o`=0x8000_0021, `count_o`=3, `empty_o`=0, each update one cycle after its acceptance.
- Set all 32 slots. Required: `full_o`=1 and `set_ready_o`=0 one cycle after the last set. Then clear slot 7: `set_ready_o`=1 the next cycle and `mask_o`=0xFFFF_FF7F.
- Set 3 twice, then clear 9 while 9 is unset. Required: one pulse each on `err_double_set_o` and `err_clr_unset_o`; `mask_o`=0x8 and `count_o`=1 throughout.
- Same-cycle set and clear of 12:
  - Bit 12 set: no error, bit stays 1, count unchanged.
  - Bit 12 unset: `err_clr_unset_o` pulses and bit 12 becomes 1.
- With `width_p`=20, set address 25. Required: `err_range_o` pulse, mask unchanged.
- Assert reset mid-stream with bits set and a set/clear pending. Required: all outputs return to reset values the next cycle; `set_ready_o` returns to 1 one cycle after release.
